// File: rtl/voice_scheduler.sv
// Polyphony controller: allocates voices from note commands, triggers all active
// voices once per audio frame and mixes their samples into one saturated output.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int WAIT_MAX   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_on,
    input  logic [19:0]              cmd_step,
    input  logic [2:0]               cmd_meta,
    output logic                     cmd_drop,
    input  logic                     frame_req,
    output logic [20*NUM_VOICES-1:0] voice_step,
    output logic [3*NUM_VOICES-1:0]  voice_meta,
    output logic [NUM_VOICES-1:0]    voice_rst,
    output logic [NUM_VOICES-1:0]    voice_gen,
    input  logic [NUM_VOICES-1:0]    voice_ready,
    input  logic [16*NUM_VOICES-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]    active,
    output logic [15:0]              mix_sample,
    output logic                     mix_valid,
    output logic                     overrun,
    output logic                     timeout
);
    localparam int ACC_W  = 16 + $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    typedef enum logic [2:0] {IDLE, GEN, WAIT, ACC, OUT} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [NUM_VOICES-1:0]    gen_mask;
    logic [NUM_VOICES-1:0]    got;
    logic [NUM_VOICES-1:0]    got_next;
    logic [15:0]              slot [NUM_VOICES];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_term;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [15:0]              mix_sat;
    logic [IDX_W-1:0]         idx;
    logic [WCNT_W-1:0]        wait_cnt;
    logic                     pending;
    logic                     cmd_accept;
    logic                     free_found;
    logic [IDX_W-1:0]         free_idx;
    logic [NUM_VOICES-1:0]    off_match;
    logic [NUM_VOICES-1:0]    active_next;
    logic                     all_got;
    logic                     wait_expire;
    logic                     frame_start;

    // Command decode: the updated mask is also what a same-cycle frame latches.
    always_comb begin
        cmd_accept = cmd_valid && cmd_ready;
        free_found = 1'b0;
        free_idx   = '0;
        off_match  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            off_match[i] = active[i] && (voice_step[20*i +: 20] == cmd_step);
        end
        active_next = active;
        if (cmd_accept) begin
            if (cmd_on) begin
                if (free_found) active_next[free_idx] = 1'b1;
            end else begin
                active_next = active & ~off_match;
            end
        end
    end

    always_comb begin
        got_next    = got | (voice_ready & gen_mask);
        all_got     = (got_next == gen_mask);
        wait_expire = !all_got && (wait_cnt == WCNT_W'(WAIT_MAX - 1));
        frame_start = frame_req || pending;
    end

    always_comb begin
        acc_term = '0;
        if (gen_mask[idx] && got[idx])
            acc_term = {{(ACC_W-16){slot[idx][15]}}, slot[idx]};
        acc_sum = acc + acc_term;
        if (acc_sum > SAT_HI)
            mix_sat = 16'h7fff;
        else if (acc_sum < SAT_LO)
            mix_sat = 16'h8000;
        else
            mix_sat = acc_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = GEN;
            GEN:     state_next = (gen_mask == '0) ? OUT : WAIT;
            WAIT:    if (all_got || wait_expire) state_next = ACC;
            ACC:     if (idx == IDX_W'(NUM_VOICES - 1)) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        voice_gen = (state == GEN) ? gen_mask : '0;
        mix_valid = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active     <= '0;
            voice_step <= '0;
            voice_meta <= '0;
            voice_rst  <= '0;
            cmd_drop   <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            mix_sample <= '0;
            pending    <= 1'b0;
            gen_mask   <= '0;
            got        <= '0;
            acc        <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) slot[i] <= '0;
        end else begin
            voice_rst <= '0;
            cmd_drop  <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            active    <= active_next;
            if (cmd_accept && cmd_on) begin
                if (free_found) begin
                    voice_step[20*free_idx +: 20] <= cmd_step;
                    voice_meta[3*free_idx +: 3]   <= cmd_meta;
                    voice_rst[free_idx]           <= 1'b1;
                end else begin
                    cmd_drop <= 1'b1;
                end
            end
            // A fresh request arriving while a pending one is consumed stays queued.
            if (state == IDLE) begin
                if (frame_start) begin
                    pending  <= pending && frame_req;
                    gen_mask <= active_next;
                    got      <= '0;
                    acc      <= '0;
                    idx      <= '0;
                    wait_cnt <= '0;
                end
            end else if (frame_req) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            case (state)
                GEN: begin
                    if (gen_mask == '0) mix_sample <= '0;
                end
                WAIT: begin
                    for (int unsigned i = 0; i < NUM_VOICES; i++)
                        if (voice_ready[i] && gen_mask[i]) slot[i] <= voice_sample[16*i +: 16];
                    got      <= got_next;
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_expire) timeout <= 1'b1;
                end
                ACC: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_VOICES - 1)) mix_sample <= mix_sat;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: behavioural voice readers plus an
// allocation/mix reference model driven with randomized notes and samples.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int WM = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_on = 1'b0;
    logic [19:0]       cmd_step = '0;
    logic [2:0]        cmd_meta = '0;
    logic              cmd_drop;
    logic              frame_req = 1'b0;
    logic [20*NV-1:0]  voice_step;
    logic [3*NV-1:0]   voice_meta;
    logic [NV-1:0]     voice_rst;
    logic [NV-1:0]     voice_gen;
    logic [NV-1:0]     voice_ready;
    logic [16*NV-1:0]  voice_sample;
    logic [NV-1:0]     active;
    logic [15:0]       mix_sample;
    logic              mix_valid;
    logic              overrun;
    logic              timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    voice_scheduler #(.NUM_VOICES(NV), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on),
        .cmd_step(cmd_step), .cmd_meta(cmd_meta), .cmd_drop(cmd_drop),
        .frame_req(frame_req),
        .voice_step(voice_step), .voice_meta(voice_meta), .voice_rst(voice_rst),
        .voice_gen(voice_gen), .voice_ready(voice_ready), .voice_sample(voice_sample),
        .active(active), .mix_sample(mix_sample), .mix_valid(mix_valid),
        .overrun(overrun), .timeout(timeout)
    );

    // Voice readers: sample ready two cycles after generate; dead voices never answer.
    logic [15:0]   smp [NV];
    logic [NV-1:0] dead = '0;
    logic [NV-1:0] r1 = '0;
    logic [NV-1:0] r2 = '0;
    always @(posedge clk) begin
        r1 <= voice_gen;
        r2 <= r1;
    end
    assign voice_ready = r2 & ~dead;
    always_comb begin
        voice_sample = '0;
        for (int i = 0; i < NV; i++) voice_sample[16*i +: 16] = smp[i];
    end

    bit m_act [NV];
    int m_step [NV];

    function automatic logic [NV-1:0] model_mask();
        logic [NV-1:0] m = '0;
        for (int i = 0; i < NV; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic logic [15:0] expected_mix();
        int s = 0;
        for (int i = 0; i < NV; i++)
            if (m_act[i] && !dead[i]) s += int'($signed(smp[i]));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        frame_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 1'b0;
            m_step[i] = 0;
        end
    endtask

    task automatic send_cmd(input bit on, input int step, input logic [2:0] meta);
        logic [NV-1:0] exp_rst = '0;
        bit exp_drop = 1'b0;
        int v = -1;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (!m_act[i] && v < 0) v = i;
            if (v < 0) exp_drop = 1'b1;
            else begin
                m_act[v] = 1'b1;
                m_step[v] = step;
                exp_rst[v] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NV; i++)
                if (m_act[i] && m_step[i] == step) m_act[i] = 1'b0;
        end
        cmd_valid = 1'b1;
        cmd_on = on;
        cmd_step = 20'(step);
        cmd_meta = meta;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (voice_rst !== exp_rst || cmd_drop !== exp_drop || active !== model_mask()) begin
            failures++;
            $display("FAIL cmd_apply: rst=%b drop=%b active=%b, required rst=%b drop=%b active=%b",
                     voice_rst, cmd_drop, active, exp_rst, exp_drop, model_mask());
        end
        if (v >= 0) begin
            checks++;
            if (voice_step[20*v +: 20] !== 20'(step) || voice_meta[3*v +: 3] !== meta) begin
                failures++;
                $display("FAIL cmd_load v%0d: step=%0d meta=%b, required step=%0d meta=%b",
                         v, voice_step[20*v +: 20], voice_meta[3*v +: 3], step, meta);
            end
        end
        tick();
        checks++;
        if (voice_rst !== '0 || cmd_drop !== 1'b0) begin
            failures++;
            $display("FAIL cmd_pulse_width: rst=%b drop=%b, required 0", voice_rst, cmd_drop);
        end
    endtask

    task automatic run_frame(output int lat, output logic [15:0] mix, output logic [NV-1:0] gen_obs,
                             output int tmo_cycle);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        lat = 1;
        tmo_cycle = -1;
        gen_obs = voice_gen;
        while (!mix_valid && lat < 200) begin
            if (timeout && tmo_cycle < 0) tmo_cycle = lat;
            tick();
            lat++;
        end
        mix = mix_sample;
        if (!mix_valid) begin
            failures++;
            $display("FAIL frame_bound: no mix_valid within %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [15:0] mix;
        logic [NV-1:0] g;
        int t;
        int n_mix = 0;
        do_reset();
        checks++;
        if (cmd_ready !== 1'b1 || active !== '0 || mix_valid !== 1'b0 || mix_sample !== '0 ||
            voice_step !== '0 || voice_meta !== '0 || voice_rst !== '0 || voice_gen !== '0 ||
            cmd_drop !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: ready=%b active=%b mv=%b mix=%h gen=%b", cmd_ready, active,
                     mix_valid, mix_sample, voice_gen);
        end
        // A completed frame first so mix_sample is non-zero before the mid-frame reset.
        smp[0] = 16'd1234;
        smp[1] = 16'd10;
        send_cmd(1'b1, 111, 3'b010);
        send_cmd(1'b1, 222, 3'b110);
        run_frame(lat, mix, g, t);
        tick();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        if (mix_valid) n_mix++;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || active !== '0 || mix_sample !== '0 || voice_step !== '0 ||
            voice_meta !== '0 || voice_gen !== '0 || voice_rst !== '0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait: ready=%b active=%b mix=%h gen=%b, required 1/0/0/0",
                     cmd_ready, active, mix_sample, voice_gen);
        end
        for (int c = 0; c < 16; c++) begin
            if (mix_valid) n_mix++;
            tick();
        end
        checks++;
        if (n_mix != 0) begin
            failures++;
            $display("FAIL reset_no_mix: mix_valid pulses=%0d, required 0", n_mix);
        end
    endtask

    task automatic test_alloc();
        do_reset();
        for (int k = 0; k < 5; k++) send_cmd(1'b1, 100 * (k + 1), 3'($urandom_range(0, 7)));
        send_cmd(1'b0, 200, 3'b000);
        checks++;
        if (active !== 4'b1101) begin
            failures++;
            $display("FAIL alloc_note_off: active=%b, required 1101", active);
        end
        send_cmd(1'b1, 600, 3'b100);
        checks++;
        if (active !== 4'b1111 || voice_step[39:20] !== 20'd600) begin
            failures++;
            $display("FAIL alloc_reuse: active=%b step1=%0d, required 1111/600", active, voice_step[39:20]);
        end
    endtask

    task automatic test_mix();
        int lat;
        int t;
        logic [15:0] mix;
        logic [NV-1:0] g;
        do_reset();
        smp[0] = 16'd1000;
        smp[1] = 16'(-300);
        smp[2] = 16'd5;
        smp[3] = 16'd7;
        send_cmd(1'b1, 40, 3'b000);
        send_cmd(1'b1, 80, 3'b010);
        run_frame(lat, mix, g, t);
        checks++;
        if (lat != 8 || mix !== 16'd700 || g !== 4'b0011) begin
            failures++;
            $display("FAIL mix_basic: lat=%0d mix=%0d gen=%b, required 8/700/0011", lat, $signed(mix), g);
        end
        tick();
        checks++;
        if (mix_valid !== 1'b0 || cmd_ready !== 1'b1 || mix_sample !== 16'd700) begin
            failures++;
            $display("FAIL mix_hold: mv=%b ready=%b mix=%0d, required 0/1/700", mix_valid, cmd_ready,
                     $signed(mix_sample));
        end
    endtask

    task automatic test_saturation();
        int lat;
        int t;
        logic [15:0] mix;
        logic [NV-1:0] g;
        do_reset();
        for (int i = 0; i < NV; i++) send_cmd(1'b1, 10 + i, 3'b000);
        for (int i = 0; i < NV; i++) smp[i] = 16'd20000;
        run_frame(lat, mix, g, t);
        checks++;
        if (mix !== 16'h7fff) begin
            failures++;
            $display("FAIL sat_pos: mix=%h, required 7fff", mix);
        end
        tick();
        for (int i = 0; i < NV; i++) smp[i] = 16'(-20000);
        run_frame(lat, mix, g, t);
        checks++;
        if (mix !== 16'h8000) begin
            failures++;
            $display("FAIL sat_neg: mix=%h, required 8000", mix);
        end
        tick();
    endtask

    task automatic test_empty();
        int lat;
        int t;
        logic [15:0] mix;
        logic [NV-1:0] g;
        do_reset();
        run_frame(lat, mix, g, t);
        checks++;
        if (lat != 2 || mix !== 16'd0 || g !== '0) begin
            failures++;
            $display("FAIL empty_frame: lat=%0d mix=%h gen=%b, required 2/0000/0000", lat, mix, g);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        int t;
        int k;
        logic [15:0] mix;
        logic [15:0] exp;
        logic [NV-1:0] g;
        for (int r = 0; r < 10; r++) begin
            do_reset();
            k = $urandom_range(0, NV);
            for (int i = 0; i < k; i++) send_cmd(1'b1, $urandom_range(1, 1000) * 8 + i, 3'($urandom_range(0, 7)));
            if (k > 0 && $urandom_range(0, 1) == 1) send_cmd(1'b0, m_step[$urandom_range(0, k - 1)], 3'b000);
            if ($urandom_range(0, 1) == 1) send_cmd(1'b1, $urandom_range(1, 1000) * 8 + 7, 3'b111);
            for (int i = 0; i < NV; i++) smp[i] = 16'($urandom);
            exp = expected_mix();
            run_frame(lat, mix, g, t);
            checks++;
            if (mix !== exp || g !== model_mask() || lat != ((model_mask() == '0) ? 2 : 4 + NV)) begin
                failures++;
                $display("FAIL random_mix r%0d: mix=%h gen=%b lat=%0d, required %h/%b", r, mix, g, lat,
                         exp, model_mask());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n_mix = 0;
        int n_ovr = 0;
        int first = -1;
        int second = -1;
        int ovr_cycle = -1;
        logic [15:0] exp;
        do_reset();
        send_cmd(1'b1, 33, 3'b000);
        send_cmd(1'b1, 66, 3'b000);
        smp[0] = 16'($urandom);
        smp[1] = 16'($urandom);
        exp = expected_mix();
        for (int c = 0; c < 40; c++) begin
            frame_req = (c == 0 || c == 2 || c == 3);
            tick();
            if (mix_valid) begin
                n_mix++;
                if (first < 0) first = c + 1;
                else second = c + 1;
                checks++;
                if (mix_sample !== exp) begin
                    failures++;
                    $display("FAIL b2b_value: mix=%h, required %h", mix_sample, exp);
                end
            end
            if (overrun) begin
                n_ovr++;
                ovr_cycle = c + 1;
            end
        end
        frame_req = 1'b0;
        checks++;
        if (n_mix != 2 || first != 4 + NV || second != 2 * (4 + NV) + 1) begin
            failures++;
            $display("FAIL b2b_frames: count=%0d first=%0d second=%0d, required 2/%0d/%0d", n_mix, first,
                     second, 4 + NV, 2 * (4 + NV) + 1);
        end
        checks++;
        if (n_ovr != 1 || ovr_cycle != 4) begin
            failures++;
            $display("FAIL b2b_overrun: count=%0d cycle=%0d, required 1/4", n_ovr, ovr_cycle);
        end
    endtask

    task automatic test_timeout();
        int lat;
        int t;
        logic [15:0] mix;
        logic [15:0] exp;
        logic [NV-1:0] g;
        do_reset();
        for (int i = 0; i < NV; i++) send_cmd(1'b1, 500 + i, 3'b000);
        for (int i = 0; i < NV; i++) smp[i] = 16'($urandom_range(0, 4000));
        dead = 4'b0100;
        exp = expected_mix();
        run_frame(lat, mix, g, t);
        checks++;
        if (t != 2 + WM || lat != 2 + WM + NV || mix !== exp) begin
            failures++;
            $display("FAIL timeout_frame: tmo=%0d lat=%0d mix=%h, required %0d/%0d/%h", t, lat, mix,
                     2 + WM, 2 + WM + NV, exp);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: ready=%b timeout=%b, required 1/0", cmd_ready, timeout);
        end
        dead = '0;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) smp[i] = '0;
        test_reset();
        test_alloc();
        test_mix();
        test_saturation();
        test_empty();
        test_random();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Polyphony controller for a bank of NUM_VOICES waveform-reader voices (phase accumulator plus sine/triangle/square ROM, 2-cycle generate-to-ready latency). It allocates voices from note-on/note-off commands and drives each voice's step size, waveform select and phase reset. On every audio frame request it triggers all active voices, collects their samples, and sums them with saturation. It emits one 16-bit mixed sample per frame to the output/codec path.

## Interface
Parameters:
- NUM_VOICES, 4: number of voice readers controlled; 2..8.
- WAIT_MAX, 15: cycles allowed in WAIT before timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- cmd_valid  in  1  note command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
- cmd_on  in  1  1 = note-on, 0 = note-off.
- cmd_step  in  20  note step size (also the key for note-off matching).
- cmd_meta  in  3  waveform select for note-on (bits [2:1]: 11 square, 10 triangle, else sine).
- cmd_drop  out  1  one-cycle pulse: note-on rejected, no free voice.
- frame_req  in  1  one-cycle request for the next mixed sample.
- voice_step  out  20*NUM_VOICES  per-voice step size, voice i at [20i+19:20i].
- voice_meta  out  3*NUM_VOICES  per-voice waveform select.
- voice_rst  out  NUM_VOICES  active-high one-cycle phase reset to voice i.
- voice_gen  out  NUM_VOICES  one-cycle generate_next to voice i.
- voice_ready  in  NUM_VOICES  sample_ready from voice i.
- voice_sample  in  16*NUM_VOICES  signed sample from voice i.
- active  out  NUM_VOICES  voice-allocated flags.
- mix_sample  out  16  signed saturated sum; held between frames.
- mix_valid  out  1  one-cycle pulse, mix_sample updated.
- overrun  out  1  one-cycle pulse: frame_req dropped.
- timeout  out  1  one-cycle pulse: WAIT expired.

## Operation
- Reset (reset==0 on an edge): state IDLE; active=0; every voice_step=0 and voice_meta=0; voice_rst, voice_gen, mix_valid, cmd_drop, overrun and timeout all 0; mix_sample=0; pending flag cleared; cmd_ready=1 on the first cycle after reset. Reset mid-frame aborts the frame and does not pulse mix_valid.
- States: IDLE, GEN, WAIT, ACC, OUT. cmd_ready=1 only in IDLE.
- Note-on accepted: allocate the lowest-index inactive voice. Load step and meta, set active, pulse voice_rst for that voice the next cycle. If all voices are active: cmd_drop pulse, no state change.
- Note-off accepted: clear active for every active voice whose voice_step==cmd_step. No match means no effect and no error. voice_step/voice_meta keep their last values.
- frame_req in IDLE with a command accepted in the same cycle: the command is applied and the frame proceeds using the updated active mask.
- IDLE→GEN on frame_req or pending. Latch gen_mask=active.
- GEN (1 cycle): voice_gen=gen_mask. If gen_mask==0, go straight to OUT with sum 0.
- WAIT: on voice_ready[i] with gen_mask[i], capture voice_sample[i] into slot i and set got[i]. When got==gen_mask, go to ACC. After WAIT_MAX cycles in WAIT: timeout pulse, missing voices contribute 0, go to ACC.
- ACC: NUM_VOICES cycles, index i=0..N-1, one add per cycle. acc += sign-extended slot i if gen_mask[i]&got[i]. acc width is 16+clog2(NUM_VOICES) (18 for N=4), cleared on entering GEN.
- OUT (1 cycle): mix_sample = acc saturated to [-32768, 32767]; mix_valid=1; go to IDLE.
- frame_req outside IDLE: set pending if clear. If pending is already set: overrun pulse, request dropped.

## Timing
- frame_req high at edge E0 in IDLE: voice_gen high in cycle 1; voice ready returns in cycle 3; ACC occupies cycles 4..(3+N); mix_valid high in cycle 4+N (cycle 8 for N=4).
- Empty frame (no active voices): mix_valid in cycle 2, mix_sample=0.
- Pending frame: leaves IDLE on the cycle after OUT.
- voice_rst: high exactly 1 cycle, in the cycle after acceptance.
- cmd_drop, overrun, timeout: one cycle each, registered.

## Test plan
- Reset: drive reset=0 for 2 edges mid-WAIT → all outputs at reset values, no mix_valid; cmd_ready=1 after release.
- Allocation: 5 note-ons (steps 100, 200, 300, 400, 500) → voices 0..3 active, voice_rst pulses each once; 5th gives cmd_drop; note-off 200 → active=4'b1101; next note-on lands in voice 1.
- Mix: voices 0,1 active with model samples 1000 and -300 → mix_sample=700, mix_valid exactly 8 cycles after frame_req.
- Saturation: four voices at 20000 → 32767; four at -20000 → -32768.
- Back-to-back frames: frame_req in cycles 0, 2, 3 → two mix_valid pulses (second from pending), overrun pulse for the third.
- Timeout: voice 2 never asserts ready → timeout after 15 WAIT cycles; mix excludes voice 2; FSM returns to IDLE.
